// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one FIFO write port in bursts of up to BURST beats.
// A grant only opens when the FIFO can absorb a whole burst, counting the write still in flight.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int AW    = 7,
  parameter int BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic              o_fifo_wr_en,
  output logic [DW-1:0]     o_fifo_wr_data,
  input  logic              i_fifo_full,
  input  logic [AW:0]       i_fifo_wr_data_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST) + 1;
  localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(2**AW);
  localparam logic [AW+1:0] BURST_W  = (AW+2)'(BURST);
  localparam logic [BW-1:0] BURST_BW = BW'(BURST);
  localparam logic [BW-1:0] BURST_M1 = BW'(BURST - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t            r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_winner;
  logic [BW-1:0]     r_beat_cnt;
  logic [NREQ-1:0]   r_grant;
  logic              r_wr_en;
  logic [DW-1:0]     r_wr_data;

  logic [AW+1:0]     w_used;
  logic              w_space_ok;
  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic              w_beat_ok;
  logic              w_win_valid;
  logic              w_accept;
  logic [DW-1:0]     w_sel_data;

  // Occupancy plus the in-flight write, compared without ever wrapping below zero.
  assign w_used     = {1'b0, i_fifo_wr_data_cnt} + {{(AW+1){1'b0}}, r_wr_en};
  assign w_space_ok = (w_used + BURST_W) <= DEPTH_W;

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(idx);
      end
    end
  end

  assign w_beat_ok   = r_beat_cnt < BURST_BW;
  assign w_win_valid = i_req_valid[r_winner];
  assign w_accept    = (r_state == ST_GRANT) && w_win_valid && o_req_ready[r_winner];
  assign w_sel_data  = i_req_data[r_winner*DW +: DW];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign o_req_ready[gi] = (r_state == ST_GRANT) && r_grant[gi] && !i_fifo_full && w_beat_ok;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= IW'(NREQ - 1);
      r_winner   <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_data <= w_sel_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_space_ok) begin
            r_state    <= ST_GRANT;
            r_winner   <= w_pick;
            r_grant    <= NREQ'(1) << w_pick;
            r_beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          // A dropped valid closes the grant even with zero beats, so the pointer still advances.
          if (!w_win_valid || (w_accept && r_beat_cnt == BURST_M1)) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= r_winner;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant        = r_grant;
  assign o_busy         = (r_state == ST_GRANT);
  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter: each row is one clock of inputs plus the outputs expected after it.
// Requester i presents data {i, seq[i]}, where seq[i] counts its own accepted beats.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              fifo_full = 1'b0;
  logic [AW:0]       cnt = '0;
  logic [3:0]        seq [NREQ];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
    assign req_data[gi*DW +: DW] = {4'(gi), seq[gi]};
  end

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .BURST(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_grant(grant), .o_busy(busy),
    .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
    .i_fifo_full(fifo_full), .i_fifo_wr_data_cnt(cnt)
  );

  typedef struct {
    logic [3:0] valid;
    logic [7:0] cnt;
    logic       full;
    logic [3:0] eg;
    logic [3:0] er;
    logic       ewe;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] v, input logic [7:0] c, input logic f,
                              input logic [3:0] eg, input logic [3:0] er, input logic we,
                              input logic [7:0] d);
    vec_t r;
    r.valid = v; r.cnt = c; r.full = f; r.eg = eg; r.er = er; r.ewe = we; r.ed = d;
    vecs.push_back(r);
  endfunction

  task automatic check_outs(input string tag, input logic [3:0] eg, input logic [3:0] er,
                            input logic we, input logic [7:0] ed);
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    chk({tag, " ready"}, 32'(req_ready), 32'(er));
    chk({tag, " busy"}, 32'(busy), 32'(eg != 4'b0000));
    chk({tag, " wr_en"}, 32'(wr_en), 32'(we));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(ed));
  endtask

  // Called at a negedge: drive one row, clock it, then check at the following negedge.
  task automatic run_vec(input vec_t v, input string tag, input int idx);
    logic [3:0] acc;
    req_valid = v.valid;
    cnt       = v.cnt;
    fifo_full = v.full;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (acc[i]) seq[i] = seq[i] + 4'd1;
    @(negedge clk);
    $display("%s[%0d] valid=%b full=%b grant=%b ready=%b busy=%b wr_en=%b data=%h",
             tag, idx, req_valid, fifo_full, grant, req_ready, busy, wr_en, wr_data);
    check_outs($sformatf("%s[%0d]", tag, idx), v.eg, v.er, v.ewe, v.ed);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], tag, i + 1);
    vecs.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    cnt = '0;
    for (int i = 0; i < NREQ; i++) seq[i] = 4'd0;
    @(posedge clk);
    @(negedge clk);
    $display("%s reset grant=%b ready=%b busy=%b wr_en=%b data=%h", tag, grant, req_ready, busy, wr_en, wr_data);
    check_outs({tag, " reset"}, 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Single requester: two back-to-back grants separated by one idle cycle, then a zero-beat grant.
    do_reset("single");
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h01);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h02);
    add(4'b0001, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h03);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h03);
    add(4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h03);
    add(4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h03);
    run_table("single");

    // Full contention: round-robin 0,1,2,3,0 with one idle cycle between grants.
    do_reset("contend");
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h01);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h02);
    add(4'b1111, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h03);
    add(4'b1111, 8'd0, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h03);
    add(4'b1111, 8'd0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h10);
    add(4'b1111, 8'd0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h11);
    add(4'b1111, 8'd0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h12);
    add(4'b1111, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h13);
    add(4'b1111, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h13);
    add(4'b1111, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h20);
    add(4'b1111, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h21);
    add(4'b1111, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h22);
    add(4'b1111, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h23);
    add(4'b1111, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'h23);
    add(4'b1111, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h30);
    add(4'b1111, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h31);
    add(4'b1111, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h32);
    add(4'b1111, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h33);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h33);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h04);
    run_table("contend");

    // Space gating, including the in-flight write keeping free space at 3 for one cycle.
    do_reset("space");
    add(4'b1111, 8'd125, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b1111, 8'd125, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00);
    add(4'b1111, 8'd124, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b1111, 8'd124, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    add(4'b1111, 8'd124, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h01);
    add(4'b1111, 8'd124, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h02);
    add(4'b1111, 8'd124, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h03);
    add(4'b1111, 8'd124, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h03);
    add(4'b1111, 8'd124, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h03);
    run_table("space");

    // Early end: requester 2 drops after two beats, requester 3 wins over requester 0.
    do_reset("early");
    add(4'b0100, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b0, 8'h00);
    add(4'b0100, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h20);
    add(4'b0100, 8'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h21);
    add(4'b1001, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h21);
    add(4'b1001, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b0, 8'h21);
    add(4'b1001, 8'd0, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h30);
    run_table("early");

    // Full stall: three full cycles mid-burst, then the remaining beats in order.
    do_reset("stall");
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    add(4'b0001, 8'd0, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h00);
    add(4'b0001, 8'd0, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h00);
    add(4'b0001, 8'd0, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'h00);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h01);
    add(4'b0001, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h02);
    add(4'b0001, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h03);
    add(4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h03);
    run_table("stall");

    // Reset mid-burst: asynchronous clear between edges, then requester 0 wins first again.
    do_reset("midrst");
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h01);
    run_table("midrst");
    #2;
    rst = 1'b1;
    #1;
    $display("midrst async grant=%b ready=%b busy=%b wr_en=%b data=%h", grant, req_ready, busy, wr_en, wr_data);
    check_outs("midrst async", 4'b0000, 4'b0000, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    $display("midrst held grant=%b ready=%b busy=%b wr_en=%b data=%h", grant, req_ready, busy, wr_en, wr_data);
    check_outs("midrst held", 4'b0000, 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b0, 8'h00);
    add(4'b1111, 8'd0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h02);
    run_table("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one FIFO write port.
REQ-002 Parameter DW, default 8: data width; equals the FIFO write data width.
REQ-003 Parameter AW, default 7: FIFO write address width; FIFO depth DEPTH = 2^AW.
REQ-004 Parameter BURST, default 4: maximum beats per grant; power of two, 1..DEPTH/2.
REQ-005 clk  in  1  sole clock; the FIFO write clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NREQ  per-requester data valid.
REQ-008 req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
REQ-009 req_ready  out  NREQ  per-requester accept; a beat transfers when valid and ready are both high.
REQ-010 grant  out  NREQ  one-hot current owner; all zero when no grant is active.
REQ-011 busy  out  1  high while a grant is active.
REQ-012 fifo_wr_en  out  1  FIFO write enable, registered.
REQ-013 fifo_wr_data  out  DW  FIFO write data, registered.
REQ-014 fifo_full  in  1  FIFO full flag.
REQ-015 fifo_wr_data_cnt  in  AW+1  FIFO write-side occupancy count.

Function
REQ-016 FSM states: IDLE and GRANT; reset state is IDLE.
REQ-017 Free-space rule: free = DEPTH - fifo_wr_data_cnt - fifo_wr_en (the in-flight write), computed at AW+2 bits with no wrap.
REQ-018 IDLE exit rule: leave IDLE only when any req_valid is high and free >= BURST.
  - Winner: the first requester with valid high, searching upward modulo NREQ from rr_ptr+1.
  - Next cycle: grant = one-hot(winner), state GRANT, beat_cnt = 0.
REQ-019 In IDLE, req_ready and grant are all zero.
REQ-020 In GRANT, req_ready[winner] = !fifo_full and beat_cnt < BURST; all other ready bits are 0.
REQ-021 Each accepted beat increments beat_cnt (width log2(BURST)+1).
  - Next cycle: fifo_wr_en = 1 and fifo_wr_data = that requester's data.
  - Otherwise fifo_wr_en = 0 and fifo_wr_data holds its last value.
REQ-022 GRANT ends when the final (BURST-th) beat is accepted, or when req_valid[winner] is low in any GRANT cycle.
  - Next cycle: state IDLE, grant = 0, rr_ptr = winner.
REQ-023 A grant ending with zero beats still updates rr_ptr.
REQ-024 IDLE lasts at least one cycle between grants, so no two grants are adjacent.
REQ-025 Latency: req_valid rising in IDLE (with space available) gives grant/ready at cycle +1 and the first fifo_wr_en at cycle +2.
REQ-026 Full safety: fifo_full high in GRANT forces ready low; the grant stays open; beats resume when fifo_full falls.
REQ-027 fifo_wr_en shall never assert for a beat accepted while fifo_full was high.
REQ-028 Throughput: one beat per cycle while the winner holds valid high and the FIFO is not full.
REQ-029 Requesters whose valid is low are skipped in the round-robin; a lone requester may win consecutive grants.
REQ-030 busy = (state == GRANT).

Reset
REQ-031 Asserting rst at any time, including mid-burst, asynchronously forces the reset values.
  - State IDLE, rr_ptr = NREQ-1 (requester 0 has first priority), beat_cnt = 0.
  - grant = 0, req_ready = 0, busy = 0, fifo_wr_en = 0, fifo_wr_data = 0.
REQ-032 Beats accepted before reset but not yet written are discarded.
REQ-033 Release of rst is synchronous to clk; the first arbitration may occur on the first clk edge after release.

Verification
REQ-034 Single requester: req_valid=0001 held 6 cycles, FIFO empty.
  - Expect grant=0001 at cycle 1, fifo_wr_en at cycles 2-5 (4 beats), IDLE at cycle 5.
  - Expect a new grant=0001 at cycle 6.
REQ-035 Contention: req_valid=1111 held continuously.
  - Expect grant order 0001, 0010, 0100, 1000, 0001, each 4 beats, one idle cycle between grants.
REQ-036 Space gating: fifo_wr_data_cnt=125, DEPTH=128, all valid.
  - Expect no grant and fifo_wr_en=0.
  - Dropping cnt to 124 gives a grant on the next cycle.
REQ-037 Early end: requester 2 drops valid after 2 beats.
  - Expect exactly 2 writes, grant cleared the next cycle, and the next grant going to requester 3 when it is valid.
REQ-038 Full stall: fifo_full forced high for 3 cycles mid-burst.
  - Expect ready=0 and no fifo_wr_en for those beats.
  - Expect the burst to complete all 4 beats afterward, in order.
REQ-039 Reset mid-burst: rst pulsed after beat 2.
  - Expect all outputs 0 immediately.
  - After release with req_valid=1111, expect grant=0001 first.
